disk_cmd_sequencer: RTL and testbench
=====================================

DISK_CMD_SEQUENCER -- requirements
Module: disk_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd16_000_000: host-response timeout in clk cycles.
REQ-002 Parameter SECTOR_BYTES, default 10'd512: data strobes expected per sector transfer.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester request level, bit n = requester n.
REQ-006 req_cmd  in  6  {cmd1,cmd0}; 3-bit codes 1=SEEK, 2=READSECT, 3=WRITESECT, 4=READID, others invalid.
REQ-007 req_addr  in  34  {addr1,addr0}; 17-bit addr = {drive, side, track[6:0], sector[7:0]}.
REQ-008 gnt  out  2  one-hot grant, held from issue until release.
REQ-009 done  out  2  one-cycle completion pulse to the granted requester.
REQ-010 err  out  1  error status of last completed command, valid from done pulse until next done.
REQ-011 timeout  out  1  set with err when the last command expired.
REQ-012 result_id  out  16  {host_cr[31:24], host_cr[15:8]} captured at completion (sector id, track).
REQ-013 host_sr  out  32  command word to host: [7:0] sector, [14:8] track, [15] side, [16] ack-of-ack, [18:17] read drive one-hot, [21:20] write drive one-hot, [23:22] readid drive one-hot, [25:24] seek drive one-hot, others 0.
REQ-014 host_cr  in  32  host status: [4] sector/id done, [3] error, [1:0] seek done per drive, [15:8] track, [31:24] sector id.
REQ-015 data_strobe  in  1  one-cycle pulse per byte moved between host and FDC FIFOs.

Function
REQ-016 States: IDLE, ISSUE, WAIT, RELEASE; one command outstanding at a time.
REQ-017 IDLE: any req bit high selects a requester round-robin; the requester not granted last wins ties; after reset requester 0 has priority.
REQ-018 On selection, cmd/addr are latched, gnt is set, and the next state is ISSUE; later req/cmd/addr changes are ignored until IDLE.
REQ-019 An invalid cmd pulses done with err=1 and timeout=0 one cycle after selection, issues no host command, and moves to RELEASE.
REQ-020 ISSUE (1 cycle): host_sr gets the latched address fields, the drive one-hot in the field for the cmd (drive 0 -> 2'b01, drive 1 -> 2'b10), and bit16=0; byte and timeout counters clear; next state is WAIT.
REQ-021 WAIT: READSECT/WRITESECT count data_strobe in a 10-bit counter saturating at SECTOR_BYTES; SEEK/READID ignore strobes.
REQ-022 Completion condition: host_cr[4] for READSECT/WRITESECT/READID; host_cr[drive] for SEEK.
REQ-023 On completion: clear the command field; set host_sr[16]=1; capture result_id; pulse done[g]; set err = host_cr[3] OR (read/write AND count != SECTOR_BYTES); set timeout=0; go to RELEASE.
REQ-024 A completion and a data_strobe in the same cycle: the strobe is counted before the short-transfer check.
REQ-025 The timeout counter increments each WAIT cycle; when it reaches TIMEOUT_CYCLES without completion, treat it as completion with err=1, timeout=1, and result_id unchanged.
REQ-026 RELEASE: hold host_sr[16]=1 until host_cr[4] and host_cr[1:0] are all 0, then clear host_sr to 0, drop gnt, and return to IDLE the next cycle.
REQ-027 Dropping req during a grant does not abort the command; done still pulses.
REQ-028 Latency: issue one cycle after selection; done one cycle after the completion condition is sampled.

Reset
REQ-029 rst asynchronously forces IDLE, gnt=0, done=0, err=0, timeout=0, result_id=0, host_sr=0, counters=0, and round-robin pointer to requester 0.
REQ-030 Reset mid-command drops the host command immediately; no done pulse is generated.

Structure
REQ-031 Shared package fdc_pkg holds: cmd codes, host_sr/host_cr bit-position constants, and the state enum.
REQ-032 One sub-module, disk_rr_arb: 2-way round-robin arbiter with a last-grant register.

Verification
REQ-033 req=2'b01, cmd0=READSECT, addr0={0,0,7'd5,8'hC1}: host_sr=32'h0002_05C1; 512 strobes then host_cr[4]=1 -> done=2'b01, err=0, host_sr[16]=1.
REQ-034 req=2'b11 held through two commands: grants go 01 then 10; a third request goes back to 01.
REQ-035 WRITESECT with 511 strobes and host_cr[4]=1, host_cr[3]=0 -> err=1, timeout=0.
REQ-036 SEEK drive 1, track 40: host_sr[25:24]=2'b10, [14:8]=40; host_cr[1]=1 -> done, err=0; host_cr cleared -> host_sr=0, gnt=0.
REQ-037 TIMEOUT_CYCLES=100, READID with no host response: done at cycle 100 of WAIT, err=1, timeout=1.
REQ-038 rst pulsed mid-WAIT of READSECT: host_sr=0 and gnt=0 asynchronously, no done; a new request is then served normally.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared definitions for the floppy-disk command sequencer: command codes,
// host status/command word bit positions, FSM state encoding and a helper
// that builds the host command word for a latched command.
package fdc_pkg;

    localparam logic [2:0] CMD_SEEK      = 3'd1;
    localparam logic [2:0] CMD_READSECT  = 3'd2;
    localparam logic [2:0] CMD_WRITESECT = 3'd3;
    localparam logic [2:0] CMD_READID    = 3'd4;

    // host_sr field positions
    localparam int SR_ACK_BIT   = 16;
    localparam int SR_READ_LO   = 17;
    localparam int SR_WRITE_LO  = 20;
    localparam int SR_READID_LO = 22;
    localparam int SR_SEEK_LO   = 24;

    // host_cr field positions
    localparam int CR_DONE_BIT = 4;
    localparam int CR_ERR_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
    } fdc_state_t;

    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        return (cmd == CMD_SEEK) || (cmd == CMD_READSECT) ||
               (cmd == CMD_WRITESECT) || (cmd == CMD_READID);
    endfunction

    // Address fields in [15:0], drive one-hot placed in the command's field.
    function automatic logic [31:0] cmd_word(input logic [2:0] cmd, input logic [16:0] addr);
        logic [31:0] w;
        logic [1:0]  drv;
        drv = addr[16] ? 2'b10 : 2'b01;
        w   = {16'h0000, addr[15:0]};
        case (cmd)
            CMD_SEEK:      w[SR_SEEK_LO   +: 2] = drv;
            CMD_READSECT:  w[SR_READ_LO   +: 2] = drv;
            CMD_WRITESECT: w[SR_WRITE_LO  +: 2] = drv;
            CMD_READID:    w[SR_READID_LO +: 2] = drv;
            default:       w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/disk_rr_arb.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins; after reset requester 0 has priority (last grant reads as 1).
module disk_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last_q;
    logic last_d;

    // Pick a winner and advance the last-grant pointer when the grant is taken
    always_comb begin
        gnt_vld = |req;
        gnt_idx = (req == 2'b11) ? ~last_q : req[1];
        last_d  = last_q;
        if (accept && gnt_vld) begin
            last_d = gnt_idx;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/disk_cmd_sequencer.sv
// Serialises disk commands from two requesters onto a single host command
// word: arbitrate, issue, wait for host completion or timeout, then hand
// shake the acknowledge back down before accepting the next request.
module disk_cmd_sequencer
    import fdc_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000,
    parameter logic [9:0]  SECTOR_BYTES   = 10'd512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [5:0]  req_cmd,
    input  logic [33:0] req_addr,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        timeout,
    output logic [15:0] result_id,
    output logic [31:0] host_sr,
    input  logic [31:0] host_cr,
    input  logic        data_strobe
);

    fdc_state_t  state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [16:0] addr_q, addr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic [15:0] result_id_q, result_id_d;
    logic [31:0] host_sr_q, host_sr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] tmo_q, tmo_d;

    logic        arb_vld;
    logic        arb_idx;
    logic        is_rw;
    logic        complete;
    logic [9:0]  cnt_inc;
    logic [23:0] tmo_inc;

    // Host status bits this block never looks at
    logic unused_cr;
    assign unused_cr = ^{host_cr[23:16], host_cr[7:5], host_cr[2]};

    disk_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .accept  (state_q == ST_IDLE),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // Completion detect and WAIT-cycle counters; a strobe in the completion
    // cycle is already folded into cnt_inc before the short-transfer check
    always_comb begin
        is_rw    = (cmd_q == CMD_READSECT) || (cmd_q == CMD_WRITESECT);
        complete = (cmd_q == CMD_SEEK) ? host_cr[addr_q[16]] : host_cr[CR_DONE_BIT];
        cnt_inc  = cnt_q;
        if (is_rw && data_strobe && (cnt_q != SECTOR_BYTES)) begin
            cnt_inc = cnt_q + 10'd1;
        end
        tmo_inc  = tmo_q + 24'd1;
    end

    // Next-state and output logic for the command FSM
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        err_d       = err_q;
        timeout_d   = timeout_q;
        result_id_d = result_id_q;
        host_sr_d   = host_sr_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    cmd_d   = arb_idx ? req_cmd[5:3]    : req_cmd[2:0];
                    addr_d  = arb_idx ? req_addr[33:17] : req_addr[16:0];
                    gnt_d   = arb_idx ? 2'b10 : 2'b01;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!cmd_is_valid(cmd_q)) begin
                    done_d    = gnt_q;
                    err_d     = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = ST_RELEASE;
                end else begin
                    host_sr_d = cmd_word(cmd_q, addr_q);
                    cnt_d     = 10'd0;
                    tmo_d     = 24'd0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                tmo_d = tmo_inc;
                if (complete) begin
                    host_sr_d   = {15'h0000, 1'b1, host_sr_q[15:0]};
                    result_id_d = {host_cr[31:24], host_cr[15:8]};
                    done_d      = gnt_q;
                    err_d       = host_cr[CR_ERR_BIT] | (is_rw && (cnt_inc != SECTOR_BYTES));
                    timeout_d   = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (tmo_inc == TIMEOUT_CYCLES) begin
                    host_sr_d = {15'h0000, 1'b1, host_sr_q[15:0]};
                    done_d    = gnt_q;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!host_cr[CR_DONE_BIT] && (host_cr[1:0] == 2'b00)) begin
                    host_sr_d = 32'h0;
                    gnt_d     = 2'b00;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 3'd0;
            addr_q      <= 17'd0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            result_id_q <= 16'h0000;
            host_sr_q   <= 32'h0;
            cnt_q       <= 10'd0;
            tmo_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            result_id_q <= result_id_d;
            host_sr_q   <= host_sr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign result_id = result_id_q;
    assign host_sr   = host_sr_q;

endmodule

// File: tb/tb_disk_cmd_sequencer.sv
// Directed plus randomized bench for disk_cmd_sequencer with a transaction
// level reference model (arbitration pointer, expected command word, error).
module tb_disk_cmd_sequencer;

    localparam logic [23:0] TMO = 24'd700;
    localparam int          SB  = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [5:0]  req_cmd = 6'd0;
    logic [33:0] req_addr = 34'd0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        timeout;
    logic [15:0] result_id;
    logic [31:0] host_sr;
    logic [31:0] host_cr = 32'h0;
    logic        data_strobe = 1'b0;

    disk_cmd_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .SECTOR_BYTES   (10'd512)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .timeout     (timeout),
        .result_id   (result_id),
        .host_sr     (host_sr),
        .host_cr     (host_cr),
        .data_strobe (data_strobe)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          last_g   = 1;
    logic [15:0] rid_m    = 16'h0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected command word straight from the host_sr field table
    function automatic logic [31:0] exp_sr(input logic [2:0] c, input logic [16:0] a);
        int lo;
        case (c)
            3'd1:    lo = 24;
            3'd2:    lo = 17;
            3'd3:    lo = 20;
            default: lo = 22;
        endcase
        return {16'h0, a[15:0]} | (32'(a[16] ? 2 : 1) << lo);
    endfunction

    task automatic do_cmd(input int r, input logic [2:0] c, input logic [16:0] a,
                          input int nstb, input bit herr, input bit respond,
                          input bit both, input bit hold_req, input bit coincide);
        int          win;
        int          k;
        int          cnt;
        bit          rw;
        bit          exp_e;
        logic [31:0] hcr;
        win = both ? (1 - last_g) : r;
        req_cmd  = 6'($urandom);
        req_addr = {2'($urandom_range(0, 3)), $urandom()};
        if (win == 0) begin
            req_cmd[2:0]   = c;
            req_addr[16:0] = a;
        end else begin
            req_cmd[5:3]    = c;
            req_addr[33:17] = a;
        end
        req = both ? 2'b11 : 2'(1 << win);
        data_strobe = 1'b0;
        host_cr = 32'h0;
        @(negedge clk);
        last_g = win;
        check("gnt_select", 32'(gnt), 32'(1 << win));
        check("done_at_select", 32'(done), 32'h0);
        if (!hold_req) req = 2'b00;
        req_cmd  = 6'($urandom);
        req_addr = {2'($urandom_range(0, 3)), $urandom()};
        @(negedge clk);
        if (c == 3'd0 || c > 3'd4) begin
            check("inv_done", 32'(done), 32'(1 << win));
            check("inv_err", 32'(err), 32'h1);
            check("inv_timeout", 32'(timeout), 32'h0);
            check("inv_host_sr", host_sr, 32'h0);
            check("inv_result_id", 32'(result_id), 32'(rid_m));
            @(negedge clk);
            check("inv_gnt_drop", 32'(gnt), 32'h0);
            check("inv_done_pulse", 32'(done), 32'h0);
            return;
        end
        check("issue_host_sr", host_sr, exp_sr(c, a));
        check("issue_done", 32'(done), 32'h0);
        rw  = (c == 3'd2) || (c == 3'd3);
        hcr = 32'h0;
        hcr[31:24] = 8'($urandom);
        hcr[15:8]  = 8'($urandom);
        hcr[3]     = herr;
        if (c == 3'd1) hcr[a[16]] = 1'b1;
        else           hcr[4] = 1'b1;
        for (int i = 0; i < nstb; i++) begin
            data_strobe = 1'b1;
            if (respond && coincide && i == nstb - 1) host_cr = hcr;
            @(negedge clk);
        end
        data_strobe = 1'b0;
        if (respond) begin
            if (!(coincide && nstb > 0)) begin
                host_cr = hcr;
                @(negedge clk);
            end
            cnt   = (nstb > SB) ? SB : nstb;
            exp_e = herr | (rw && cnt != SB);
            rid_m = {hcr[31:24], hcr[15:8]};
            check("cpl_done", 32'(done), 32'(1 << win));
            check("cpl_err", 32'(err), 32'(exp_e));
            check("cpl_timeout", 32'(timeout), 32'h0);
            check("cpl_result_id", 32'(result_id), 32'(rid_m));
            check("cpl_host_sr", host_sr, 32'h0001_0000 | 32'(a[15:0]));
            @(negedge clk);
            check("cpl_done_pulse", 32'(done), 32'h0);
            repeat ($urandom_range(0, 3)) begin
                check("rel_hold_sr", host_sr, 32'h0001_0000 | 32'(a[15:0]));
                check("rel_hold_gnt", 32'(gnt), 32'(1 << win));
                @(negedge clk);
            end
            host_cr = 32'h0;
            @(negedge clk);
            check("rel_host_sr", host_sr, 32'h0);
            check("rel_gnt", 32'(gnt), 32'h0);
        end else begin
            k = nstb;
            while (done == 2'b00 && k < int'(TMO) + 5) begin
                @(negedge clk);
                k++;
            end
            check("tmo_cycles", 32'(k), 32'(TMO));
            check("tmo_done", 32'(done), 32'(1 << win));
            check("tmo_err", 32'(err), 32'h1);
            check("tmo_flag", 32'(timeout), 32'h1);
            check("tmo_result_id", 32'(result_id), 32'(rid_m));
            check("tmo_host_sr", host_sr, 32'h0001_0000 | 32'(a[15:0]));
            @(negedge clk);
            check("tmo_done_pulse", 32'(done), 32'h0);
            check("tmo_rel_sr", host_sr, 32'h0);
            check("tmo_rel_gnt", 32'(gnt), 32'h0);
        end
    endtask

    task automatic reset_mid();
        req      = 2'b01;
        req_cmd  = {3'd0, 3'd2};
        req_addr = {17'd0, 17'h0_0A10};
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        check("pre_rst_host_sr", host_sr, 32'h0002_0A10);
        data_strobe = 1'b1;
        repeat (10) @(negedge clk);
        data_strobe = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_host_sr", host_sr, 32'h0);
        check("rst_async_gnt", 32'(gnt), 32'h0);
        check("rst_async_done", 32'(done), 32'h0);
        check("rst_async_err", 32'(err), 32'h0);
        check("rst_async_result_id", 32'(result_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_g = 1;
        rid_m  = 16'h0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'h0);
        end
    endtask

    initial begin
        int          r;
        int          nstb;
        logic [2:0]  c;
        logic [16:0] a;
        bit          resp;
        bit          coin;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        check("reset_result_id", 32'(result_id), 32'h0);
        check("reset_host_sr", host_sr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Tie held through two commands, then a third tie: 01, 10, 01
        do_cmd(0, 3'd1, 17'h0_1203, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tie_first", 32'(last_g), 32'd0);
        do_cmd(0, 3'd4, 17'h1_0707, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tie_second", 32'(last_g), 32'd1);
        do_cmd(0, 3'd1, 17'h0_2201, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("tie_third", 32'(last_g), 32'd0);

        // Full sector read, track 5 sector C1
        check("sr_table_example", exp_sr(3'd2, {1'b0, 1'b0, 7'd5, 8'hC1}), 32'h0002_05C1);
        do_cmd(0, 3'd2, {1'b0, 1'b0, 7'd5, 8'hC1}, 512, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Short write, strobe coinciding with completion, saturation, host error
        do_cmd(1, 3'd3, 17'h0_3322, 511, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd(0, 3'd2, 17'h1_0410, 512, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_cmd(1, 3'd3, 17'h1_8001, 514, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd(0, 3'd4, 17'h0_0102, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Seek drive 1 track 40
        check("sr_table_seek", exp_sr(3'd1, {1'b1, 1'b0, 7'd40, 8'h00}), 32'h0200_2800);
        do_cmd(1, 3'd1, {1'b1, 1'b0, 7'd40, 8'h00}, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // READID with no host response
        do_cmd(0, 3'd4, 17'h0_4455, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Invalid codes
        do_cmd(1, 3'd0, 17'h1_FFFF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd(0, 3'd7, 17'h0_1111, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of a read, then a normal request
        reset_mid();
        do_cmd(1, 3'd2, 17'h0_1E22, 512, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_tie", 32'(last_g), 32'd0);

        for (int t = 0; t < 24; t++) begin
            r    = $urandom_range(0, 1);
            c    = 3'($urandom_range(0, 9) < 8 ? $urandom_range(1, 4) : $urandom_range(0, 7));
            a    = 17'($urandom);
            resp = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       nstb = $urandom_range(0, 4);
                1:       nstb = $urandom_range(508, 514);
                2:       nstb = 512;
                default: nstb = $urandom_range(0, 520);
            endcase
            coin = resp && ($urandom_range(0, 3) == 0);
            do_cmd(r, c, a, nstb, 1'($urandom_range(0, 4) == 0), resp,
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), coin);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("final_idle_gnt", 32'(gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
